// File: rtl/round_key_store.sv
// Captures AES round keys from the key expander into an NR+1 slot table (slot 0 = cipher key)
// and serves them to the cipher datapath with a registered, one-cycle read port.
module round_key_store #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [KW-1:0] cipher_key,
  output logic          busy,
  output logic          done,
  output logic          seq_error,
  output logic [KW-1:0] kexp_key,
  output logic          kexp_enable,
  output logic          kexp_ack,
  input  logic          kexp_ready,
  input  logic [3:0]    kexp_round,
  input  logic [KW-1:0] kexp_key_out,
  input  logic          rd_en,
  input  logic [3:0]    rd_idx,
  output logic [KW-1:0] rd_key,
  output logic          rd_valid
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StWaitRdy = 3'd2;
  localparam logic [2:0] StWaitLow = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [3:0] LastRnd = 4'(NR);

  logic [2:0]    state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          en_q, en_d;
  logic          ack_q, ack_d;
  logic [KW-1:0] key_q, key_d;
  logic [NR:0]   valid_q, valid_d;
  logic [KW-1:0] slot_q [NR+1];
  logic          slot_we;
  logic [3:0]    slot_widx;
  logic [KW-1:0] slot_wdata;
  logic [KW-1:0] rd_key_q;
  logic          rd_valid_q;

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    done_d     = done_q;
    err_d      = err_q;
    en_d       = en_q;
    ack_d      = 1'b0;
    key_d      = key_q;
    valid_d    = valid_q;
    slot_we    = 1'b0;
    slot_widx  = rnd_q;
    slot_wdata = kexp_key_out;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          key_d      = cipher_key;
          valid_d    = '0;
          valid_d[0] = 1'b1;
          err_d      = 1'b0;
          rnd_d      = 4'd1;
          done_d     = 1'b0;
          slot_we    = 1'b1;
          slot_widx  = 4'd0;
          slot_wdata = cipher_key;
        end
      end
      StLoad: begin
        en_d    = 1'b1;
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (kexp_ready) begin
          if (kexp_round == rnd_q) begin
            slot_we        = 1'b1;
            valid_d[rnd_q] = 1'b1;
            ack_d          = 1'b1;
            state_d        = StWaitLow;
          end else begin
            err_d   = 1'b1;
            en_d    = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StWaitLow: begin
        // The expander keeps ready up after the ack; wait for it to drop before the next round.
        if (!kexp_ready) begin
          if (rnd_q == LastRnd) begin
            state_d = StDone;
            done_d  = 1'b1;
            en_d    = 1'b0;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = StWaitRdy;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StLoad) || (state_d == StWaitRdy) || (state_d == StWaitLow);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rnd_q   <= 4'd1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
      key_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i <= NR; i++) begin
        slot_q[i] <= '0;
      end
    end else if (slot_we) begin
      slot_q[slot_widx] <= slot_wdata;
    end
  end

  // Reads see pre-edge table contents, so a same-cycle write returns old data and valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      if (rd_idx <= LastRnd) begin
        rd_key_q   <= slot_q[rd_idx];
        rd_valid_q <= valid_q[rd_idx];
      end else begin
        rd_key_q   <= '0;
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign seq_error   = err_q;
  assign kexp_key    = key_q;
  assign kexp_enable = en_q;
  assign kexp_ack    = ack_q;
  assign rd_key      = rd_key_q;
  assign rd_valid    = rd_valid_q;

endmodule
